// File: rtl/id_hazard_scoreboard.sv
// rtl/id_hazard_scoreboard.sv - decode-stage GPR scoreboard, issue stall control, stall watchdog and perf counter
module id_hazard_scoreboard #(
    parameter int CNT_W     = 2,
    parameter bit WB_BYPASS = 1'b0,
    parameter int TIMEOUT   = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ds_valid,
    input  logic [4:0]  ds_rj,
    input  logic        ds_rj_used,
    input  logic [4:0]  ds_rkd,
    input  logic        ds_rkd_used,
    input  logic [4:0]  ds_dest,
    input  logic        ds_gr_we,
    input  logic        es_allow_in,
    input  logic        ws_valid,
    input  logic        ws_rf_we,
    input  logic [4:0]  ws_rf_waddr,
    output logic        ds_ready_go,
    output logic        issue_fire,
    output logic [31:0] busy_vec,
    output logic        deadlock,
    output logic        underflow_err,
    output logic [31:0] stall_cycles
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_STALL, S_HUNG} state_t;

    logic [CNT_W-1:0]  r_cnt [32];
    state_t            r_state;
    state_t            w_state_nxt;
    logic [WAIT_W-1:0] r_wait;
    logic [WAIT_W-1:0] w_wait_nxt;
    logic [WAIT_W-1:0] w_wait_inc;
    logic              r_deadlock;
    logic              r_underflow;
    logic [31:0]       r_stall_cycles;

    logic              w_issue;
    logic              w_retire;
    logic              w_haz_rj;
    logic              w_haz_rkd;
    logic              w_sat_haz;
    logic              w_stall;
    logic [CNT_W-1:0]  w_cnt_rj;
    logic [CNT_W-1:0]  w_cnt_rkd;
    logic [CNT_W-1:0]  w_cnt_dest;
    logic [CNT_W-1:0]  w_cnt_wb;

    assign w_cnt_rj   = r_cnt[ds_rj];
    assign w_cnt_rkd  = r_cnt[ds_rkd];
    assign w_cnt_dest = r_cnt[ds_dest];
    assign w_cnt_wb   = r_cnt[ws_rf_waddr];

    assign w_retire = ws_valid && ws_rf_we && (ws_rf_waddr != 5'd0);

    // Write-through release only applies to the last outstanding write of that register
    assign w_haz_rj  = ds_rj_used && (ds_rj != 5'd0) && (w_cnt_rj != '0) &&
                       !(WB_BYPASS && w_retire && (ws_rf_waddr == ds_rj) && (w_cnt_rj == CNT_W'(1)));
    assign w_haz_rkd = ds_rkd_used && (ds_rkd != 5'd0) && (w_cnt_rkd != '0) &&
                       !(WB_BYPASS && w_retire && (ws_rf_waddr == ds_rkd) && (w_cnt_rkd == CNT_W'(1)));
    assign w_sat_haz = ds_gr_we && (ds_dest != 5'd0) && (w_cnt_dest == CNT_MAX);

    assign ds_ready_go = !(w_haz_rj || w_haz_rkd || w_sat_haz);
    assign issue_fire  = ds_valid && ds_ready_go && es_allow_in;
    assign w_issue     = issue_fire && ds_gr_we && (ds_dest != 5'd0);
    assign w_stall     = ds_valid && !ds_ready_go;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 32; i++) begin
                if (w_issue && (ds_dest == 5'(i)) && !(w_retire && (ws_rf_waddr == 5'(i)))) begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end else if (w_retire && (ws_rf_waddr == 5'(i)) && !(w_issue && (ds_dest == 5'(i))) &&
                             (r_cnt[i] != '0)) begin
                    r_cnt[i] <= r_cnt[i] - CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        busy_vec = '0;
        for (int i = 0; i < 32; i++) begin
            busy_vec[i] = (r_cnt[i] != '0);
        end
    end

    assign w_wait_inc = r_wait + WAIT_W'(1);

    always_comb begin
        w_state_nxt = r_state;
        w_wait_nxt  = r_wait;
        case (r_state)
            S_IDLE: begin
                if (w_stall) begin
                    w_wait_nxt  = WAIT_W'(1);
                    w_state_nxt = (TIMEOUT <= 1) ? S_HUNG : S_STALL;
                end
            end
            S_STALL: begin
                if (!w_stall) begin
                    w_wait_nxt  = '0;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_wait_nxt  = w_wait_inc;
                    w_state_nxt = (w_wait_inc == WAIT_W'(TIMEOUT)) ? S_HUNG : S_STALL;
                end
            end
            S_HUNG: begin
                if (!w_stall) begin
                    w_wait_nxt  = '0;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_wait_nxt  = '0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_wait         <= '0;
            r_deadlock     <= 1'b0;
            r_underflow    <= 1'b0;
            r_stall_cycles <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait     <= w_wait_nxt;
            r_deadlock <= r_deadlock || (w_state_nxt == S_HUNG);
            r_underflow <= r_underflow || (w_retire && (w_cnt_wb == '0));
            if (w_stall && (r_stall_cycles != 32'hFFFF_FFFF)) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
        end
    end

    assign deadlock      = r_deadlock;
    assign underflow_err = r_underflow;
    assign stall_cycles  = r_stall_cycles;

endmodule

// File: tb/tb_id_hazard_scoreboard.sv
// tb/tb_id_hazard_scoreboard.sv - scoreboard bench for id_hazard_scoreboard against a per-register in-flight count model
module tb_id_hazard_scoreboard;

    localparam int CNT_W = 2;
    localparam bit BYP   = 1'b0;
    localparam int TMO   = 64;
    localparam int MAXC  = (1 << CNT_W) - 1;

    logic        clk;
    logic        rst;
    logic        ds_valid;
    logic [4:0]  ds_rj;
    logic        ds_rj_used;
    logic [4:0]  ds_rkd;
    logic        ds_rkd_used;
    logic [4:0]  ds_dest;
    logic        ds_gr_we;
    logic        es_allow_in;
    logic        ws_valid;
    logic        ws_rf_we;
    logic [4:0]  ws_rf_waddr;
    logic        ds_ready_go;
    logic        issue_fire;
    logic [31:0] busy_vec;
    logic        deadlock;
    logic        underflow_err;
    logic [31:0] stall_cycles;

    id_hazard_scoreboard #(.CNT_W(CNT_W), .WB_BYPASS(BYP), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .ds_valid(ds_valid), .ds_rj(ds_rj), .ds_rj_used(ds_rj_used),
        .ds_rkd(ds_rkd), .ds_rkd_used(ds_rkd_used), .ds_dest(ds_dest), .ds_gr_we(ds_gr_we),
        .es_allow_in(es_allow_in), .ws_valid(ws_valid), .ws_rf_we(ws_rf_we), .ws_rf_waddr(ws_rf_waddr),
        .ds_ready_go(ds_ready_go), .issue_fire(issue_fire), .busy_vec(busy_vec),
        .deadlock(deadlock), .underflow_err(underflow_err), .stall_cycles(stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        ready;
        logic        fire;
        logic [31:0] busy;
        logic        dead;
        logic        under;
        logic [31:0] stalls;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;

    int          m_cnt[32];
    bit          m_dead;
    bit          m_under;
    int unsigned m_stall;
    int          m_run;
    int          inflight[$];

    function automatic void chk(string name, logic [31:0] got, logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", name, got, want, $time);
        end
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) m_cnt[i] = 0;
        m_dead = 0; m_under = 0; m_stall = 0; m_run = 0;
        inflight.delete();
    endfunction

    function automatic bit haz(int a, bit used, bit ret, int wa);
        return used && a != 0 && m_cnt[a] > 0 && !(BYP && ret && wa == a && m_cnt[a] == 1);
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("ds_ready_go",   32'(ds_ready_go),   32'(e.ready));
            chk("issue_fire",    32'(issue_fire),    32'(e.fire));
            chk("busy_vec",      busy_vec,           e.busy);
            chk("deadlock",      32'(deadlock),      32'(e.dead));
            chk("underflow_err", 32'(underflow_err), 32'(e.under));
            chk("stall_cycles",  stall_cycles,       e.stalls);
        end
    end

    task automatic step();
        exp_t e;
        bit ret, rdy, iss;
        int wa, dst;
        wa  = int'(ws_rf_waddr);
        dst = int'(ds_dest);
        ret = ws_valid && ws_rf_we && wa != 0;
        rdy = !(haz(int'(ds_rj), ds_rj_used, ret, wa) || haz(int'(ds_rkd), ds_rkd_used, ret, wa) ||
                (ds_gr_we && dst != 0 && m_cnt[dst] == MAXC));
        e.ready = rdy;
        e.fire  = ds_valid && rdy && es_allow_in;
        for (int i = 0; i < 32; i++) e.busy[i] = (m_cnt[i] != 0);
        e.dead   = m_dead;
        e.under  = m_under;
        e.stalls = m_stall;
        exp_q.push_back(e);
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            if (ds_valid && !rdy) begin
                if (m_stall != 32'hFFFF_FFFF) m_stall++;
                m_run++;
                if (m_run >= TMO) m_dead = 1;
            end else begin
                m_run = 0;
            end
            iss = ds_valid && rdy && es_allow_in && ds_gr_we && dst != 0;
            if (ret && m_cnt[wa] == 0) m_under = 1;
            if (iss) inflight.push_back(dst);
            if (!(iss && ret && dst == wa)) begin
                if (iss) m_cnt[dst]++;
                if (ret && m_cnt[wa] > 0) m_cnt[wa]--;
            end
        end
        #1;
    endtask

    task automatic drv(input bit v, input int rj, input bit rju, input int rk, input bit rku,
                       input int d, input bit we, input bit allow, input bit wv, input bit wwe, input int wa);
        ds_valid = v; ds_rj = 5'(rj); ds_rj_used = rju; ds_rkd = 5'(rk); ds_rkd_used = rku;
        ds_dest = 5'(d); ds_gr_we = we; es_allow_in = allow;
        ws_valid = wv; ws_rf_we = wwe; ws_rf_waddr = 5'(wa);
    endtask

    initial begin
        int budget;
        rst = 1'b1;
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        model_reset();
        rst = 1'b0;

        repeat (2) step();
        // producer r5, dependent reader, retire, release the cycle after WB
        drv(1, 1, 1, 2, 1, 5, 1, 1, 0, 0, 0); step();
        drv(1, 5, 1, 0, 0, 6, 1, 1, 0, 0, 0); repeat (3) step();
        drv(1, 5, 1, 0, 0, 6, 1, 1, 1, 1, 5); step();
        drv(1, 5, 1, 0, 0, 6, 1, 1, 0, 0, 0); step();
        drv(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 6); step();
        // two in-flight writes to r7
        drv(1, 0, 0, 0, 0, 7, 1, 1, 0, 0, 0); repeat (2) step();
        drv(1, 7, 1, 0, 0, 0, 0, 1, 1, 1, 7); step();
        drv(1, 0, 0, 7, 1, 0, 0, 1, 0, 0, 0); step();
        drv(1, 0, 0, 7, 1, 0, 0, 1, 1, 1, 7); step();
        drv(1, 0, 0, 7, 1, 0, 0, 1, 0, 0, 0); step();
        // r0 never tracked
        drv(1, 0, 1, 0, 1, 0, 1, 1, 0, 0, 0); repeat (2) step();
        // same-cycle issue and retire of r3
        drv(1, 0, 0, 0, 0, 3, 1, 1, 0, 0, 0); step();
        drv(1, 0, 0, 0, 0, 3, 1, 1, 1, 1, 3); step();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); step();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 3); step();
        // underflow on r9
        drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 9); step();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); repeat (2) step();
        rst = 1'b1; step(); rst = 1'b0; step();

        for (int n = 0; n < 800; n++) begin
            ds_valid    = ($urandom_range(0, 3) != 0);
            ds_rj       = 5'($urandom_range(0, 7));
            ds_rj_used  = ($urandom_range(0, 3) != 0);
            ds_rkd      = 5'($urandom_range(0, 7));
            ds_rkd_used = ($urandom_range(0, 2) != 0);
            ds_dest     = 5'($urandom_range(0, 7));
            ds_gr_we    = ($urandom_range(0, 3) != 0);
            es_allow_in = ($urandom_range(0, 4) != 0);
            if (inflight.size() > 0 && $urandom_range(0, 2) == 0) begin
                ws_valid = 1'b1; ws_rf_we = 1'b1; ws_rf_waddr = 5'(inflight.pop_front());
            end else begin
                ws_valid = ($urandom_range(0, 7) == 0); ws_rf_we = 1'b0;
                ws_rf_waddr = 5'($urandom_range(0, 31));
            end
            step();
        end

        // hold a hazard past the watchdog limit, then reset mid-operation
        rst = 1'b1; drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); step(); rst = 1'b0;
        drv(1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0); step();
        drv(1, 5, 1, 0, 0, 0, 0, 1, 0, 0, 0); repeat (70) step();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); step();
        rst = 1'b1; step(); rst = 1'b0;
        repeat (2) step();

        budget = 10;
        while (exp_q.size() > 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        if (exp_q.size() > 0) chk("drain", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
